// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_AF_THRESH = 6;
    localparam int DEF_AE_THRESH = 2;

    // Pointer width: address bits plus one wrap bit. This is also the width
    // of the occupancy count, which must represent 0..DEPTH inclusive.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle between the FIFO and the logic driving it.
interface fifo_sync_param_if #(
    parameter int DATA_W = fifo_pkg::DEF_DATA_W,
    parameter int DEPTH  = fifo_pkg::DEF_DEPTH
);
    import fifo_pkg::*;

    localparam int CNT_W = ptr_w(DEPTH);

    logic              clr;
    logic              wr_rq;
    logic [DATA_W-1:0] wdata;
    logic              rd_rq;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    // Producer/consumer side: issues requests, observes data and status.
    modport master (
        output clr, wr_rq, wdata, rd_rq,
        input  rdata, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  clr, wr_rq, wdata, rd_rq,
        output rdata, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the word at the write address on an accepted write.
    // NOTE: storage has no reset on purpose; occupancy is tracked by the
    // pointers, so stale contents are never presented as valid data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO: occupancy count, programmable almost flags,
// sticky overflow/underflow, synchronous flush, optional first-word-fall-through.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH,
    parameter bit FWFT      = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_sync_param_if.slave   bus
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    // Elaboration-time parameter sanity.
    if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two in 2..64");
    end
    if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
        $error("fifo_sync_param: AE_THRESH must be below AF_THRESH");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
        $error("fifo_sync_param: DATA_W must be in 1..32");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  count_w;
    logic              full_w;
    logic              empty_w;
    logic              wr_acc;
    logic              rd_acc;
    logic              overflow_q;
    logic              underflow_q;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata_o;
    logic              rd_valid_o;

    // Status is derived purely from registered pointers, so every flag
    // reflects accepted operations from the cycle after the accepting edge.
    assign count_w = wr_ptr - rd_ptr;
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // A flush cycle ignores both requests. A read never sees a word written
    // in the same cycle; a write at full is accepted only alongside a read.
    assign rd_acc = bus.rd_rq && !empty_w && !bus.clr;
    assign wr_acc = bus.wr_rq && (!full_w || rd_acc) && !bus.clr;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (bus.wdata),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    // Pointer advance, flush and sticky error flags.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (bus.wr_rq && !wr_acc) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_rq && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    if (FWFT) begin : g_fwft
        // Head word shown directly; forced to zero while empty so the bus
        // never carries stale storage contents.
        assign rdata_o    = empty_w ? '0 : mem_rdata;
        assign rd_valid_o = !empty_w;
    end else begin : g_registered
        logic [DATA_W-1:0] rdata_q;
        logic              rd_valid_q;

        // Read register: capture the head on an accepted read, flag it valid
        // for exactly one cycle; data holds otherwise (including on flush).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q    <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= mem_rdata;
                end
            end
        end

        assign rdata_o    = rdata_q;
        assign rd_valid_o = rd_valid_q;
    end

    assign bus.rdata        = rdata_o;
    assign bus.rd_valid     = rd_valid_o;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_w >= PTR_W'(AF_THRESH));
    assign bus.almost_empty = (count_w <= PTR_W'(AE_THRESH));
    assign bus.count        = count_w;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a registered-read FIFO and an FWFT FIFO driven with
// identical stimulus, both compared against one queue-based reference model.
module tb_fifo_sync_param;

    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk;
    logic rst_n;

    fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) if0 ();
    fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) if1 ();

    fifo_sync_param #(
        .DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)
    ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    fifo_sync_param #(
        .DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)
    ) u_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic          m_unf;
    logic          m_vld;
    logic [DW-1:0] m_rdata;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_vld   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic compare_all();
        int n;
        n = q.size();
        check("r_count",  32'(if0.count), 32'(n));
        check("r_full",   32'(if0.full), 32'(n == DEPTH));
        check("r_empty",  32'(if0.empty), 32'(n == 0));
        check("r_afull",  32'(if0.almost_full), 32'(n >= AF));
        check("r_aempty", 32'(if0.almost_empty), 32'(n <= AE));
        check("r_ovf",    32'(if0.overflow), 32'(m_ovf));
        check("r_unf",    32'(if0.underflow), 32'(m_unf));
        check("r_valid",  32'(if0.rd_valid), 32'(m_vld));
        check("r_rdata",  32'(if0.rdata), 32'(m_rdata));
        check("f_count",  32'(if1.count), 32'(n));
        check("f_ovf",    32'(if1.overflow), 32'(m_ovf));
        check("f_unf",    32'(if1.underflow), 32'(m_unf));
        check("f_valid",  32'(if1.rd_valid), 32'(n != 0));
        if (n != 0) begin
            check("f_rdata", 32'(if1.rdata), 32'(q[0]));
        end
    endtask

    // One clock of stimulus: drive both FIFOs, advance the model by the
    // behavioural rules, then sample 1 ns after the edge.
    task automatic cycle(input logic wr, input logic [DW-1:0] wd,
                         input logic rd, input logic c);
        bit rd_ok;
        bit wr_ok;
        if0.wr_rq = wr; if0.wdata = wd; if0.rd_rq = rd; if0.clr = c;
        if1.wr_rq = wr; if1.wdata = wd; if1.rd_rq = rd; if1.clr = c;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_vld = 1'b0;
        end else begin
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
            if (rd && q.size() == 0) m_unf = 1'b1;
            if (wr && !wr_ok)        m_ovf = 1'b1;
            if (rd_ok) m_rdata = q.pop_front();
            m_vld = rd_ok;
            if (wr_ok) q.push_back(wd);
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        if0.wr_rq = 1'b0; if0.wdata = '0; if0.rd_rq = 1'b0; if0.clr = 1'b0;
        if1.wr_rq = 1'b0; if1.wdata = '0; if1.rd_rq = 1'b0; if1.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("f_rst_rdata", 32'(if1.rdata), 32'h0);
        rst_n = 1'b1;

        // Fill 1..8: almost_full from count 6, full after the eighth edge.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        check("fill_full", 32'(if0.full), 32'h1);

        // Write alone at full is dropped; write+read at full both accepted.
        cycle(1'b1, 4'h9, 1'b0, 1'b0);
        check("ovf_set", 32'(if0.overflow), 32'h1);
        cycle(1'b1, 4'hA, 1'b1, 1'b0);
        check("full_wr_rd_cnt", 32'(if0.count), 32'd8);

        // Drain: 2..8 then 0xA, each valid one cycle after its request.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("drain_last", 32'(if0.rdata), 32'hA);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Empty boundary: read+write on empty -> underflow, no data, count 1.
        cycle(1'b1, 4'h5, 1'b1, 1'b0);
        check("empty_unf", 32'(if0.underflow), 32'h1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("empty_rd5", 32'(if0.rdata), 32'h5);

        // Flush from count 5 with sticky flags set.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(i + 3), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("clr_empty", 32'(if0.empty), 32'h1);
        cycle(1'b1, 4'h7, 1'b1, 1'b1);
        check("clr_ign_cnt", 32'(if0.count), 32'h0);

        // Wrap-around: 20 write-then-read pairs of incrementing data.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'(i + 1), 1'b0, 1'b0);
            check("wrap_le1", 32'(if0.count <= 1), 32'h1);
            cycle(1'b0, '0, 1'b1, 1'b0);
            check("wrap_data", 32'(if0.rdata), 32'((i + 1) % 16));
        end

        // FWFT: a write is visible next cycle with no read request.
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        check("fwft_show", 32'(if1.rdata), 32'h3);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("fwft_pop", 32'(if1.rd_valid), 32'h0);

        // Randomised traffic, biased to visit both full and empty.
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 50) % 2;
            cycle(($urandom_range(0, 9) < (bias ? 7 : 3)),
                  DW'($urandom),
                  ($urandom_range(0, 9) < (bias ? 3 : 7)),
                  ($urandom_range(0, 59) == 0));
        end

        // Asynchronous reset mid-read: outputs return to reset values at once.
        cycle(1'b1, 4'hC, 1'b0, 1'b0);
        cycle(1'b1, 4'hD, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        if0.wr_rq = 1'b0; if0.rd_rq = 1'b0;
        if1.wr_rq = 1'b0; if1.rd_rq = 1'b0;
        @(posedge clk);
        #1;
        check("rst_no_valid", 32'(if0.rd_valid), 32'h0);
        rst_n = 1'b1;
        cycle(1'b1, 4'hE, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("post_rst_rd", 32'(if0.rdata), 32'hE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
